// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizes, types and id helpers for the reorder buffer
package reorder_buffer_pkg;

   localparam int ROB_SIZE    = 16;
   localparam int FULL_MARGIN = 2;
   localparam int ROB_ID_W    = $clog2(ROB_SIZE + 1);
   localparam int IDX_W       = $clog2(ROB_SIZE);

   typedef logic [ROB_ID_W-1:0] rob_id_t;
   typedef logic [IDX_W-1:0]    rob_idx_t;
   typedef logic [31:0]         data_t;
   typedef logic [31:0]         addr_t;
   typedef logic [4:0]          reg_pos_t;

   localparam rob_id_t ZERO_ROB = '0;
   localparam logic    TRUE     = 1'b1;
   localparam logic    FALSE    = 1'b0;

   // External ids are index+1 so that 0 can mean "no dependency".
   function automatic rob_idx_t id_to_idx(input rob_id_t id);
      rob_id_t t;
      t = id - rob_id_t'(1);
      return t[IDX_W-1:0];
   endfunction

   function automatic rob_id_t idx_to_id(input rob_idx_t idx);
      return rob_id_t'(idx) + rob_id_t'(1);
   endfunction

   function automatic logic id_in_range(input rob_id_t id);
      return (id != ZERO_ROB) && (id <= rob_id_t'(ROB_SIZE));
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order-commit reorder buffer with CDB capture and operand queries
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     ena_from_dsp,
   input  reg_pos_t rd_from_dsp,
   input  addr_t    pc_from_dsp,
   input  logic     is_store_from_dsp,
   input  logic     is_branch_from_dsp,
   output rob_id_t  rob_id_to_dsp,
   input  rob_id_t  Q1_from_dsp,
   input  rob_id_t  Q2_from_dsp,
   output logic     Q1_ready_to_dsp,
   output logic     Q2_ready_to_dsp,
   output data_t    ready_data1_to_dsp,
   output data_t    ready_data2_to_dsp,
   input  logic     valid_from_rs_cdb,
   input  rob_id_t  rob_id_from_rs_cdb,
   input  data_t    result_from_rs_cdb,
   input  logic     jump_flag_from_rs_cdb,
   input  addr_t    target_pc_from_rs_cdb,
   input  logic     valid_from_ls_cdb,
   input  rob_id_t  rob_id_from_ls_cdb,
   input  data_t    result_from_ls_cdb,
   output logic     full_to_if,
   output logic     commit_reg_flag_to_reg,
   output reg_pos_t commit_rd_to_reg,
   output rob_id_t  commit_rob_id_to_reg,
   output data_t    commit_data_to_reg,
   output logic     commit_store_flag_to_lsb,
   output rob_id_t  commit_rob_id_to_lsb,
   output logic     commit_jump_flag,
   output addr_t    target_pc_to_if
);

   localparam rob_idx_t LAST_IDX    = rob_idx_t'(ROB_SIZE - 1);
   localparam rob_id_t  CAPACITY    = rob_id_t'(ROB_SIZE);
   localparam rob_id_t  FULL_THRESH = rob_id_t'(ROB_SIZE - FULL_MARGIN);

   rob_idx_t head_q, head_d, tail_q, tail_d;
   rob_id_t  count_q, count_d;
   logic     flush_pending_q, flush_pending_d;

   logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
   logic [ROB_SIZE-1:0] is_store_q, is_store_d, is_branch_q, is_branch_d;
   logic [ROB_SIZE-1:0] jump_q, jump_d;
   reg_pos_t rd_q     [ROB_SIZE];
   reg_pos_t rd_d     [ROB_SIZE];
   addr_t    pc_q     [ROB_SIZE];
   addr_t    pc_d     [ROB_SIZE];
   addr_t    target_q [ROB_SIZE];
   addr_t    target_d [ROB_SIZE];
   data_t    data_q   [ROB_SIZE];
   data_t    data_d   [ROB_SIZE];

   logic     c_reg_flag_q, c_reg_flag_d, c_store_flag_q, c_store_flag_d;
   logic     c_jump_q, c_jump_d;
   reg_pos_t c_rd_q, c_rd_d;
   rob_id_t  c_reg_id_q, c_reg_id_d, c_lsb_id_q, c_lsb_id_d;
   data_t    c_data_q, c_data_d;
   addr_t    c_target_q, c_target_d;

   logic     commit_fire, alloc_fire;
   rob_idx_t rs_idx, ls_idx;
   addr_t    head_pc_unused;

   assign rob_id_to_dsp  = idx_to_id(tail_q);
   assign full_to_if     = (count_q >= FULL_THRESH);
   assign rs_idx         = id_to_idx(rob_id_from_rs_cdb);
   assign ls_idx         = id_to_idx(rob_id_from_ls_cdb);
   assign head_pc_unused = pc_q[head_q];

   always_comb begin
      Q1_ready_to_dsp    = FALSE;
      ready_data1_to_dsp = '0;
      Q2_ready_to_dsp    = FALSE;
      ready_data2_to_dsp = '0;
      if (id_in_range(Q1_from_dsp)) begin
         Q1_ready_to_dsp    = busy_q[id_to_idx(Q1_from_dsp)] & ready_q[id_to_idx(Q1_from_dsp)];
         ready_data1_to_dsp = data_q[id_to_idx(Q1_from_dsp)];
      end
      if (id_in_range(Q2_from_dsp)) begin
         Q2_ready_to_dsp    = busy_q[id_to_idx(Q2_from_dsp)] & ready_q[id_to_idx(Q2_from_dsp)];
         ready_data2_to_dsp = data_q[id_to_idx(Q2_from_dsp)];
      end
   end

   always_comb begin
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      flush_pending_d = flush_pending_q;
      busy_d          = busy_q;
      ready_d         = ready_q;
      is_store_d      = is_store_q;
      is_branch_d     = is_branch_q;
      jump_d          = jump_q;
      rd_d            = rd_q;
      pc_d            = pc_q;
      target_d        = target_q;
      data_d          = data_q;
      c_reg_flag_d    = FALSE;
      c_store_flag_d  = FALSE;
      c_jump_d        = FALSE;
      c_rd_d          = '0;
      c_reg_id_d      = ZERO_ROB;
      c_lsb_id_d      = ZERO_ROB;
      c_data_d        = '0;
      c_target_d      = '0;
      commit_fire     = FALSE;
      alloc_fire      = FALSE;

      // The flush request survives rdy=0 so a stalled cycle cannot lose it.
      if (rdy) begin
         if (flush_pending_q) begin
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
            flush_pending_d = FALSE;
            busy_d          = '0;
            ready_d         = '0;
         end else begin
            commit_fire = busy_q[head_q] & ready_q[head_q];
            alloc_fire  = ena_from_dsp && (count_q < CAPACITY);

            if (valid_from_rs_cdb && id_in_range(rob_id_from_rs_cdb) && busy_q[rs_idx]) begin
               data_d[rs_idx]   = result_from_rs_cdb;
               ready_d[rs_idx]  = TRUE;
               jump_d[rs_idx]   = jump_flag_from_rs_cdb;
               target_d[rs_idx] = target_pc_from_rs_cdb;
            end
            if (valid_from_ls_cdb && id_in_range(rob_id_from_ls_cdb) && busy_q[ls_idx]) begin
               data_d[ls_idx]  = result_from_ls_cdb;
               ready_d[ls_idx] = TRUE;
            end

            if (commit_fire) begin
               busy_d[head_q]  = FALSE;
               ready_d[head_q] = FALSE;
               head_d          = (head_q == LAST_IDX) ? '0 : head_q + rob_idx_t'(1);
               if (is_store_q[head_q]) begin
                  c_store_flag_d = TRUE;
                  c_lsb_id_d     = idx_to_id(head_q);
               end else begin
                  c_reg_flag_d = TRUE;
                  c_rd_d       = rd_q[head_q];
                  c_reg_id_d   = idx_to_id(head_q);
                  c_data_d     = data_q[head_q];
               end
               if (is_branch_q[head_q] && jump_q[head_q]) begin
                  c_jump_d        = TRUE;
                  c_target_d      = target_q[head_q];
                  flush_pending_d = TRUE;
               end
            end

            if (alloc_fire) begin
               busy_d[tail_q]      = TRUE;
               ready_d[tail_q]     = FALSE;
               jump_d[tail_q]      = FALSE;
               is_store_d[tail_q]  = is_store_from_dsp;
               is_branch_d[tail_q] = is_branch_from_dsp;
               rd_d[tail_q]        = rd_from_dsp;
               pc_d[tail_q]        = pc_from_dsp;
               tail_d              = (tail_q == LAST_IDX) ? '0 : tail_q + rob_idx_t'(1);
            end

            count_d = count_q + rob_id_t'(alloc_fire) - rob_id_t'(commit_fire);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         flush_pending_q <= FALSE;
         busy_q          <= '0;
         ready_q         <= '0;
         is_store_q      <= '0;
         is_branch_q     <= '0;
         jump_q          <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            rd_q[i]     <= '0;
            pc_q[i]     <= '0;
            target_q[i] <= '0;
            data_q[i]   <= '0;
         end
         c_reg_flag_q   <= FALSE;
         c_store_flag_q <= FALSE;
         c_jump_q       <= FALSE;
         c_rd_q         <= '0;
         c_reg_id_q     <= ZERO_ROB;
         c_lsb_id_q     <= ZERO_ROB;
         c_data_q       <= '0;
         c_target_q     <= '0;
      end else begin
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         flush_pending_q <= flush_pending_d;
         busy_q          <= busy_d;
         ready_q         <= ready_d;
         is_store_q      <= is_store_d;
         is_branch_q     <= is_branch_d;
         jump_q          <= jump_d;
         rd_q            <= rd_d;
         pc_q            <= pc_d;
         target_q        <= target_d;
         data_q          <= data_d;
         c_reg_flag_q    <= c_reg_flag_d;
         c_store_flag_q  <= c_store_flag_d;
         c_jump_q        <= c_jump_d;
         c_rd_q          <= c_rd_d;
         c_reg_id_q      <= c_reg_id_d;
         c_lsb_id_q      <= c_lsb_id_d;
         c_data_q        <= c_data_d;
         c_target_q      <= c_target_d;
      end
   end

   assign commit_reg_flag_to_reg   = c_reg_flag_q;
   assign commit_rd_to_reg         = c_rd_q;
   assign commit_rob_id_to_reg     = c_reg_id_q;
   assign commit_data_to_reg       = c_data_q;
   assign commit_store_flag_to_lsb = c_store_flag_q;
   assign commit_rob_id_to_lsb     = c_lsb_id_q;
   assign commit_jump_flag         = c_jump_q;
   assign target_pc_to_if          = c_target_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic     clk, rst, rdy;
   logic     ena_from_dsp, is_store_from_dsp, is_branch_from_dsp;
   reg_pos_t rd_from_dsp;
   addr_t    pc_from_dsp;
   rob_id_t  rob_id_to_dsp, Q1_from_dsp, Q2_from_dsp;
   logic     Q1_ready_to_dsp, Q2_ready_to_dsp;
   data_t    ready_data1_to_dsp, ready_data2_to_dsp;
   logic     valid_from_rs_cdb, jump_flag_from_rs_cdb, valid_from_ls_cdb;
   rob_id_t  rob_id_from_rs_cdb, rob_id_from_ls_cdb;
   data_t    result_from_rs_cdb, result_from_ls_cdb;
   addr_t    target_pc_from_rs_cdb;
   logic     full_to_if, commit_reg_flag_to_reg, commit_store_flag_to_lsb, commit_jump_flag;
   reg_pos_t commit_rd_to_reg;
   rob_id_t  commit_rob_id_to_reg, commit_rob_id_to_lsb;
   data_t    commit_data_to_reg;
   addr_t    target_pc_to_if;

   int total = 0;
   int bad   = 0;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp), .pc_from_dsp(pc_from_dsp),
      .is_store_from_dsp(is_store_from_dsp), .is_branch_from_dsp(is_branch_from_dsp),
      .rob_id_to_dsp(rob_id_to_dsp),
      .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
      .Q1_ready_to_dsp(Q1_ready_to_dsp), .Q2_ready_to_dsp(Q2_ready_to_dsp),
      .ready_data1_to_dsp(ready_data1_to_dsp), .ready_data2_to_dsp(ready_data2_to_dsp),
      .valid_from_rs_cdb(valid_from_rs_cdb), .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
      .result_from_rs_cdb(result_from_rs_cdb), .jump_flag_from_rs_cdb(jump_flag_from_rs_cdb),
      .target_pc_from_rs_cdb(target_pc_from_rs_cdb),
      .valid_from_ls_cdb(valid_from_ls_cdb), .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
      .result_from_ls_cdb(result_from_ls_cdb),
      .full_to_if(full_to_if),
      .commit_reg_flag_to_reg(commit_reg_flag_to_reg), .commit_rd_to_reg(commit_rd_to_reg),
      .commit_rob_id_to_reg(commit_rob_id_to_reg), .commit_data_to_reg(commit_data_to_reg),
      .commit_store_flag_to_lsb(commit_store_flag_to_lsb), .commit_rob_id_to_lsb(commit_rob_id_to_lsb),
      .commit_jump_flag(commit_jump_flag), .target_pc_to_if(target_pc_to_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rdy = 1'b1;
      ena_from_dsp = 1'b0; rd_from_dsp = '0; pc_from_dsp = '0;
      is_store_from_dsp = 1'b0; is_branch_from_dsp = 1'b0;
      Q1_from_dsp = '0; Q2_from_dsp = '0;
      valid_from_rs_cdb = 1'b0; rob_id_from_rs_cdb = '0; result_from_rs_cdb = '0;
      jump_flag_from_rs_cdb = 1'b0; target_pc_from_rs_cdb = '0;
      valid_from_ls_cdb = 1'b0; rob_id_from_ls_cdb = '0; result_from_ls_cdb = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic alloc(input reg_pos_t rd, input logic st, input logic br);
      ena_from_dsp = 1'b1; rd_from_dsp = rd; is_store_from_dsp = st; is_branch_from_dsp = br;
      pc_from_dsp = 32'h100 + 32'(rd);
      tick();
      ena_from_dsp = 1'b0; is_store_from_dsp = 1'b0; is_branch_from_dsp = 1'b0;
   endtask

   task automatic rs_write(input rob_id_t id, input data_t d, input logic j, input addr_t t);
      valid_from_rs_cdb = 1'b1; rob_id_from_rs_cdb = id; result_from_rs_cdb = d;
      jump_flag_from_rs_cdb = j; target_pc_from_rs_cdb = t;
      tick();
      valid_from_rs_cdb = 1'b0; jump_flag_from_rs_cdb = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (rob_id_to_dsp !== 5'd1) begin bad++; $display("FAIL reset_rob_id got=%0d want=1", rob_id_to_dsp); end
      total++; if (full_to_if !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", full_to_if); end
      total++; if ({commit_reg_flag_to_reg, commit_store_flag_to_lsb, commit_jump_flag} !== 3'b000) begin
         bad++; $display("FAIL reset_commit_flags got=%0b want=0", {commit_reg_flag_to_reg, commit_store_flag_to_lsb, commit_jump_flag});
      end
   endtask

   task automatic test_alloc();
      for (int i = 1; i <= 3; i++) begin
         total++; if (rob_id_to_dsp !== rob_id_t'(i)) begin bad++; $display("FAIL alloc_id got=%0d want=%0d", rob_id_to_dsp, i); end
         alloc(reg_pos_t'(i), 1'b0, 1'b0);
         total++; if (commit_reg_flag_to_reg !== 1'b0) begin bad++; $display("FAIL alloc_no_commit got=%0b want=0", commit_reg_flag_to_reg); end
      end
      total++; if (rob_id_to_dsp !== 5'd4) begin bad++; $display("FAIL alloc_id_after3 got=%0d want=4", rob_id_to_dsp); end
   endtask

   task automatic test_cdb_query();
      rs_write(5'd2, 32'h55, 1'b0, 32'h0);
      Q1_from_dsp = 5'd2; Q2_from_dsp = 5'd1; #1;
      total++; if ({Q1_ready_to_dsp, ready_data1_to_dsp} !== {1'b1, 32'h55}) begin
         bad++; $display("FAIL query_id2 got=%0b/%0h want=1/55", Q1_ready_to_dsp, ready_data1_to_dsp);
      end
      total++; if (Q2_ready_to_dsp !== 1'b0) begin bad++; $display("FAIL query_id1_notready got=%0b want=0", Q2_ready_to_dsp); end
      Q1_from_dsp = 5'd0; #1;
      total++; if ({Q1_ready_to_dsp, ready_data1_to_dsp} !== 33'd0) begin
         bad++; $display("FAIL query_zero got=%0b/%0h want=0/0", Q1_ready_to_dsp, ready_data1_to_dsp);
      end
      tick();
      total++; if (commit_reg_flag_to_reg !== 1'b0) begin bad++; $display("FAIL head_not_ready_commit got=%0b want=0", commit_reg_flag_to_reg); end
      rs_write(5'd1, 32'h11, 1'b0, 32'h0);
      total++; if (commit_reg_flag_to_reg !== 1'b0) begin bad++; $display("FAIL same_cycle_commit got=%0b want=0", commit_reg_flag_to_reg); end
      tick();
      total++; if ({commit_reg_flag_to_reg, commit_rd_to_reg, commit_rob_id_to_reg, commit_data_to_reg} !== {1'b1, 5'd1, 5'd1, 32'h11}) begin
         bad++; $display("FAIL commit1 got=%0b/%0d/%0d/%0h want=1/1/1/11", commit_reg_flag_to_reg, commit_rd_to_reg, commit_rob_id_to_reg, commit_data_to_reg);
      end
      tick();
      total++; if ({commit_reg_flag_to_reg, commit_rd_to_reg, commit_rob_id_to_reg, commit_data_to_reg} !== {1'b1, 5'd2, 5'd2, 32'h55}) begin
         bad++; $display("FAIL commit2 got=%0b/%0d/%0d/%0h want=1/2/2/55", commit_reg_flag_to_reg, commit_rd_to_reg, commit_rob_id_to_reg, commit_data_to_reg);
      end
      tick();
      total++; if (commit_reg_flag_to_reg !== 1'b0) begin bad++; $display("FAIL commit3_absent got=%0b want=0", commit_reg_flag_to_reg); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i == 13) begin
            total++; if (full_to_if !== 1'b0) begin bad++; $display("FAIL full_at13 got=%0b want=0", full_to_if); end
         end
         alloc(reg_pos_t'(i + 1), 1'b0, 1'b0);
         if (i == 13) begin
            total++; if (full_to_if !== 1'b1) begin bad++; $display("FAIL full_at14 got=%0b want=1", full_to_if); end
         end
      end
      total++; if (rob_id_to_dsp !== 5'd1) begin bad++; $display("FAIL wrap_id got=%0d want=1", rob_id_to_dsp); end
      alloc(5'd31, 1'b0, 1'b0);
      total++; if (rob_id_to_dsp !== 5'd1) begin bad++; $display("FAIL alloc_when_full_id got=%0d want=1", rob_id_to_dsp); end
      rs_write(5'd1, 32'hAAA, 1'b0, 32'h0);
      tick();
      total++; if ({commit_reg_flag_to_reg, commit_rd_to_reg, commit_data_to_reg} !== {1'b1, 5'd1, 32'hAAA}) begin
         bad++; $display("FAIL full_entry_kept got=%0b/%0d/%0h want=1/1/aaa", commit_reg_flag_to_reg, commit_rd_to_reg, commit_data_to_reg);
      end
      total++; if (full_to_if !== 1'b1) begin bad++; $display("FAIL full_at15 got=%0b want=1", full_to_if); end
   endtask

   task automatic test_store();
      do_reset();
      alloc(5'd7, 1'b1, 1'b0);
      alloc(5'd4, 1'b0, 1'b0);
      valid_from_ls_cdb = 1'b1; rob_id_from_ls_cdb = 5'd1; result_from_ls_cdb = 32'h0;
      tick();
      valid_from_ls_cdb = 1'b0;
      tick();
      total++; if ({commit_store_flag_to_lsb, commit_rob_id_to_lsb, commit_reg_flag_to_reg} !== {1'b1, 5'd1, 1'b0}) begin
         bad++; $display("FAIL store_commit got=%0b/%0d/%0b want=1/1/0", commit_store_flag_to_lsb, commit_rob_id_to_lsb, commit_reg_flag_to_reg);
      end
      tick();
      total++; if (commit_store_flag_to_lsb !== 1'b0) begin bad++; $display("FAIL store_pulse got=%0b want=0", commit_store_flag_to_lsb); end
   endtask

   task automatic test_jump();
      do_reset();
      alloc(5'd0, 1'b0, 1'b1);
      for (int i = 2; i <= 5; i++) alloc(reg_pos_t'(i), 1'b0, 1'b0);
      for (int i = 2; i <= 5; i++) rs_write(rob_id_t'(i), 32'(i * 16), 1'b0, 32'h0);
      Q1_from_dsp = 5'd3; #1;
      total++; if ({Q1_ready_to_dsp, ready_data1_to_dsp} !== {1'b1, 32'h30}) begin
         bad++; $display("FAIL pre_flush_query got=%0b/%0h want=1/30", Q1_ready_to_dsp, ready_data1_to_dsp);
      end
      rs_write(5'd1, 32'h0, 1'b1, 32'h1000);
      tick();
      total++; if ({commit_jump_flag, target_pc_to_if} !== {1'b1, 32'h1000}) begin
         bad++; $display("FAIL jump_commit got=%0b/%0h want=1/1000", commit_jump_flag, target_pc_to_if);
      end
      alloc(5'd9, 1'b0, 1'b0);
      total++; if ({commit_jump_flag, commit_reg_flag_to_reg} !== 2'b00) begin
         bad++; $display("FAIL flush_no_commit got=%0b want=0", {commit_jump_flag, commit_reg_flag_to_reg});
      end
      total++; if (rob_id_to_dsp !== 5'd1) begin bad++; $display("FAIL flush_tail got=%0d want=1", rob_id_to_dsp); end
      Q1_from_dsp = 5'd2; Q2_from_dsp = 5'd5; #1;
      total++; if ({Q1_ready_to_dsp, Q2_ready_to_dsp} !== 2'b00) begin
         bad++; $display("FAIL flush_query got=%0b want=0", {Q1_ready_to_dsp, Q2_ready_to_dsp});
      end
      tick();
      total++; if (commit_reg_flag_to_reg !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0b want=0", commit_reg_flag_to_reg); end
   endtask

   task automatic test_rdy_and_async_reset();
      do_reset();
      alloc(5'd3, 1'b0, 1'b0);
      alloc(5'd4, 1'b0, 1'b0);
      rs_write(5'd1, 32'h77, 1'b0, 32'h0);
      rdy = 1'b0; ena_from_dsp = 1'b1; rd_from_dsp = 5'd9;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({commit_reg_flag_to_reg, rob_id_to_dsp} !== {1'b0, 5'd3}) begin
            bad++; $display("FAIL rdy_low_hold got=%0b/%0d want=0/3", commit_reg_flag_to_reg, rob_id_to_dsp);
         end
      end
      rdy = 1'b1; ena_from_dsp = 1'b0;
      tick();
      total++; if ({commit_reg_flag_to_reg, commit_rd_to_reg, commit_data_to_reg} !== {1'b1, 5'd3, 32'h77}) begin
         bad++; $display("FAIL rdy_resume_commit got=%0b/%0d/%0h want=1/3/77", commit_reg_flag_to_reg, commit_rd_to_reg, commit_data_to_reg);
      end
      rs_write(5'd2, 32'h88, 1'b0, 32'h0);
      tick();
      total++; if ({commit_reg_flag_to_reg, commit_rd_to_reg, commit_data_to_reg} !== {1'b1, 5'd4, 32'h88}) begin
         bad++; $display("FAIL commit_before_reset got=%0b/%0d/%0h want=1/4/88", commit_reg_flag_to_reg, commit_rd_to_reg, commit_data_to_reg);
      end
      #2 rst = 1'b0;
      #1;
      total++; if ({commit_reg_flag_to_reg, commit_data_to_reg, rob_id_to_dsp} !== {1'b0, 32'h0, 5'd1}) begin
         bad++; $display("FAIL async_reset got=%0b/%0h/%0d want=0/0/1", commit_reg_flag_to_reg, commit_data_to_reg, rob_id_to_dsp);
      end
      tick();
      rst = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_alloc();
      test_cdb_query();
      test_full();
      test_store();
      test_jump();
      test_rdy_and_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
